// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/execute/mem/wb).
// Optional PERF_CNT_EN macro adds free-running cycle and retired-instruction counters.
module multi_cycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  input  logic            Zero,
  input  logic            MemReady,
  output logic            PCWr,
  output logic            PCWrCond,
  output logic            IorD,
  output logic            MemRd,
  output logic            MemWr,
  output logic            IRWr,
  output logic            RegWr,
  output logic            RegDst,
  output logic            MemToReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSrc,
  output logic            Link,
  output logic            Illegal,
`ifdef PERF_CNT_EN
  output logic [31:0]     CycleCnt,
  output logic [31:0]     InstrCnt,
`endif
  output logic [ST_W-1:0] State
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'('h03);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'('h0D);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = ST_W'(0),  S_DECODE = ST_W'(1),  S_MEMADR = ST_W'(2),
    S_MEMRD  = ST_W'(3),  S_MEMWB  = ST_W'(4),  S_MEMWR  = ST_W'(5),
    S_EXEC   = ST_W'(6),  S_ALUWB  = ST_W'(7),  S_BRANCH = ST_W'(8),
    S_JUMP   = ST_W'(9),  S_IEXEC  = ST_W'(10), S_IWB    = ST_W'(11),
    S_RESET  = ST_W'(14), S_TRAP   = ST_W'(15)
  } state_e;

  typedef struct packed {
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       link;
    logic       illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   fetch_ack;

  // Moore outputs of a state; evaluated on the next state so they register in step with it.
  function automatic ctrl_t decode(input state_e s, input logic is_jal);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_rd = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR, S_IEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_rd = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_wr = 1'b1; c.iord = 1'b1; end
      S_EXEC:   c.alu_src_a = 1'b1;
      S_ALUWB:  begin c.reg_wr = 1'b1; c.reg_dst = 1'b1; end
      S_IWB:    c.reg_wr = 1'b1;
      S_BRANCH: begin c.alu_src_a = 1'b1; c.pc_wr_cond = 1'b1; c.pc_src = 2'b01; end
      S_JUMP:   begin c.pc_wr = 1'b1; c.pc_src = 2'b10; c.link = is_jal; c.reg_wr = is_jal; end
      S_TRAP:   c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:        state_d = S_EXEC;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J, OP_JAL:    state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_IEXEC;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    ctrl_d = decode(state_d, op == OP_JAL);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // IR load and PC increment complete together with the fetch handshake.
  assign fetch_ack = (state_q == S_FETCH) && MemReady;

  assign PCWr     = ctrl_q.pc_wr | fetch_ack;
  assign IRWr     = fetch_ack;
  assign PCWrCond = ctrl_q.pc_wr_cond;
  assign IorD     = ctrl_q.iord;
  assign MemRd    = ctrl_q.mem_rd;
  assign MemWr    = ctrl_q.mem_wr;
  assign RegWr    = ctrl_q.reg_wr;
  assign RegDst   = ctrl_q.reg_dst;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ALUSrcB  = ctrl_q.alu_src_b;
  assign PCSrc    = ctrl_q.pc_src;
  assign Link     = ctrl_q.link;
  assign Illegal  = ctrl_q.illegal;
  assign State    = state_q;

  // funct is decoded by the ALU controller and Zero gates PCWrCond outside this block.
  logic unused_inputs;
  assign unused_inputs = ^{funct, Zero};

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_RESET) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (state_d == S_FETCH && state_q != S_RESET && state_q != S_FETCH)
      instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class state by state.
// Compile with PERF_CNT_EN defined to also check the performance counters.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemToReg;
  logic       ALUSrcA, Link, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] State;
`ifdef PERF_CNT_EN
  logic [31:0] CycleCnt, InstrCnt;
  int unsigned cyc_model = 0;
  int unsigned instr_model = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_state = 4'hE;

  multi_cycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .Zero(Zero), .MemReady(MemReady),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemRd(MemRd), .MemWr(MemWr),
    .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .Link(Link), .Illegal(Illegal),
`ifdef PERF_CNT_EN
    .CycleCnt(CycleCnt), .InstrCnt(InstrCnt),
`endif
    .State(State)
  );

  always #5 clk = ~clk;

  // {PCWr,PCWrCond,IorD,MemRd,MemWr,IRWr,RegWr,RegDst,MemToReg,ALUSrcA,ALUSrcB,PCSrc,Link,Illegal}
  logic [16:0] outs;
  assign outs = {PCWr, PCWrCond, IorD, MemRd, MemWr, IRWr, RegWr, RegDst, MemToReg,
                 ALUSrcA, ALUSrcB, PCSrc, Link, Illegal};

  localparam logic [16:0] O_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_0_0;
  localparam logic [16:0] O_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [16:0] O_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_0_0;
  localparam logic [16:0] O_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [16:0] O_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_0_0;
  localparam logic [16:0] O_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_0_0;
  localparam logic [16:0] O_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_0_0;
  localparam logic [16:0] O_ALUWB   = 17'b0_0_0_0_0_0_1_1_0_0_00_00_0_0;
  localparam logic [16:0] O_IWB     = 17'b0_0_0_0_0_0_1_0_0_0_00_00_0_0;
  localparam logic [16:0] O_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_0_0;
  localparam logic [16:0] O_JAL     = 17'b1_0_0_0_0_0_1_0_0_0_00_10_1_0;
  localparam logic [16:0] O_J       = 17'b1_0_0_0_0_0_0_0_0_0_00_10_0_0;
  localparam logic [16:0] O_TRAP    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_0_1;
  localparam logic [16:0] O_NONE    = 17'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then compare state and the full output vector.
  task automatic step_chk(input string tag, input logic [3:0] exp_state, input logic [16:0] exp_outs);
`ifdef PERF_CNT_EN
    if (prev_state != 4'hE) cyc_model++;
    if (exp_state == 4'h0 && prev_state != 4'hE && prev_state != 4'h0) instr_model++;
`endif
    @(posedge clk);
    #1;
    check({tag, ".state"}, 32'(State), 32'(exp_state));
    check({tag, ".outs"}, 32'(outs), 32'(exp_outs));
`ifdef PERF_CNT_EN
    check({tag, ".cyc"}, CycleCnt, cyc_model);
    check({tag, ".instr"}, InstrCnt, instr_model);
`endif
    prev_state = exp_state;
  endtask

  initial begin
    rst = 1'b1; op = 6'h23; funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    #2;
    check("reset.state", 32'(State), 32'hE);
    check("reset.outs", 32'(outs), 32'(O_NONE));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // lw with zero-wait memory: 0,1,2,3,4 then next FETCH
    step_chk("lw.fetch", 4'h0, O_FETCH);
    step_chk("lw.decode", 4'h1, O_DECODE);
    step_chk("lw.memadr", 4'h2, O_MEMADR);
    step_chk("lw.memrd", 4'h3, O_MEMRD);
    step_chk("lw.memwb", 4'h4, O_MEMWB);
    step_chk("lw.done", 4'h0, O_FETCH);

    // fetch stall: IRWr/PCWr follow MemReady combinationally
    MemReady = 1'b0;
    #1;
    check("fstall.mealy", 32'(outs), 32'(O_FSTALL));
    step_chk("fstall.hold", 4'h0, O_FSTALL);
    MemReady = 1'b1;
    op = 6'h2B;
    step_chk("sw.decode", 4'h1, O_DECODE);
    step_chk("sw.memadr", 4'h2, O_MEMADR);
    step_chk("sw.memwr1", 4'h5, O_MEMWR);
    MemReady = 1'b0;
    step_chk("sw.memwr2", 4'h5, O_MEMWR);
    step_chk("sw.memwr3", 4'h5, O_MEMWR);
    step_chk("sw.memwr4", 4'h5, O_MEMWR);
    MemReady = 1'b1;
    step_chk("sw.done", 4'h0, O_FETCH);

    op = 6'h00;
    step_chk("rtype.decode", 4'h1, O_DECODE);
    step_chk("rtype.exec", 4'h6, O_EXEC);
    step_chk("rtype.aluwb", 4'h7, O_ALUWB);
    step_chk("rtype.done", 4'h0, O_FETCH);

    op = 6'h08;
    step_chk("addi.decode", 4'h1, O_DECODE);
    step_chk("addi.iexec", 4'hA, O_MEMADR);
    step_chk("addi.iwb", 4'hB, O_IWB);
    step_chk("addi.done", 4'h0, O_FETCH);

    op = 6'h0D;
    step_chk("ori.decode", 4'h1, O_DECODE);
    step_chk("ori.iexec", 4'hA, O_MEMADR);
    step_chk("ori.iwb", 4'hB, O_IWB);
    step_chk("ori.done", 4'h0, O_FETCH);

    op = 6'h04; Zero = 1'b1;
    step_chk("beq_t.decode", 4'h1, O_DECODE);
    step_chk("beq_t.branch", 4'h8, O_BRANCH);
    step_chk("beq_t.done", 4'h0, O_FETCH);
    Zero = 1'b0;
    step_chk("beq_n.decode", 4'h1, O_DECODE);
    step_chk("beq_n.branch", 4'h8, O_BRANCH);
    step_chk("beq_n.done", 4'h0, O_FETCH);

    op = 6'h03;
    step_chk("jal.decode", 4'h1, O_DECODE);
    step_chk("jal.jump", 4'h9, O_JAL);
    step_chk("jal.done", 4'h0, O_FETCH);
    op = 6'h02;
    step_chk("j.decode", 4'h1, O_DECODE);
    step_chk("j.jump", 4'h9, O_J);
    step_chk("j.done", 4'h0, O_FETCH);

    // reset mid-MEMRD aborts immediately
    op = 6'h23;
    step_chk("abort.decode", 4'h1, O_DECODE);
    step_chk("abort.memadr", 4'h2, O_MEMADR);
    MemReady = 1'b0;
    step_chk("abort.memrd", 4'h3, O_MEMRD);
    step_chk("abort.memrd_wait", 4'h3, O_MEMRD);
    rst = 1'b1;
    #1;
    check("abort.state", 32'(State), 32'hE);
    check("abort.outs", 32'(outs), 32'(O_NONE));
    @(posedge clk); #1;
    check("abort.hold_state", 32'(State), 32'hE);
    check("abort.hold_outs", 32'(outs), 32'(O_NONE));
`ifdef PERF_CNT_EN
    cyc_model = 0; instr_model = 0;
`endif
    prev_state = 4'hE;
    MemReady = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step_chk("abort.refetch", 4'h0, O_FETCH);

    // illegal opcode traps and stays there
    op = 6'h3F;
    step_chk("trap.decode", 4'h1, O_DECODE);
    for (int i = 0; i < 12; i++) step_chk($sformatf("trap.hold%0d", i), 4'hF, O_TRAP);
    op = 6'h00;
    step_chk("trap.sticky", 4'hF, O_TRAP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
